ps2_host_tx: RTL

// - Host-to-device PS/2 command transmitter: sends one command byte (e.g. 8'hF4 enable reporting) to the mouse/keyboard.
// - Performs the full handshake: inhibit, request-to-send, 8 data bits + odd parity + stop, then checks the device ACK bit.
// - Sits beside the PS/2 receive path, sharing the PS2_CLK/PS2_DAT pins.
// - While busy=1 the receive path must ignore incoming data.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_host_tx_if.sv | 26 ++
 rtl/ps2_sync_edge.sv | 34 +++
 rtl/ps2_host_tx.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: command bytes, 50 MHz timing defaults and the
// host transmit state encoding, used by both the transmit and receive paths.
package ps2_pkg;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_DEFAULTS = 8'hF6;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_ACK          = 8'hFA;

    // 100 us inhibit, 1 us request-to-send, 15 ms device response limit
    localparam int PS2_INHIBIT_CYCLES = 5000;
    localparam int PS2_RTS_CYCLES     = 50;
    localparam int PS2_TIMEOUT_CYCLES = 750000;

    typedef enum logic [2:0] {
        TX_IDLE      = 3'd0,
        TX_INHIBIT   = 3'd1,
        TX_RTS       = 3'd2,
        TX_SHIFT     = 3'd3,
        TX_ACK       = 3'd4,
        TX_WAIT_IDLE = 3'd5,
        TX_DONE      = 3'd6,
        TX_ERROR     = 3'd7
    } tx_state_t;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a caller (master) and the PS/2 host transmitter (slave).
interface ps2_host_tx_if;

    logic [7:0] cmd_data;
    logic       cmd_send;
    logic       busy;
    logic       cmd_done;
    logic       cmd_error;

    modport master (
        output cmd_data,
        output cmd_send,
        input  busy,
        input  cmd_done,
        input  cmd_error
    );

    modport slave (
        input  cmd_data,
        input  cmd_send,
        output busy,
        output cmd_done,
        output cmd_error
    );

endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the PS/2 clock/data pin pair plus a one-cycle
// pulse on each falling edge of the synchronized clock.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_raw,
    input  logic dat_raw,
    output logic clk_s,
    output logic dat_s,
    output logic clk_fall
);

    logic [1:0] clk_ff;
    logic [1:0] dat_ff;
    logic       clk_s_d;

    // Flops reset to 1 so an idle (pulled-up) bus does not produce a fake edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_ff  <= 2'b11;
            dat_ff  <= 2'b11;
            clk_s_d <= 1'b1;
        end else begin
            clk_ff  <= {clk_ff[0], clk_raw};
            dat_ff  <= {dat_ff[0], dat_raw};
            clk_s_d <= clk_ff[1];
        end
    end

    assign clk_s    = clk_ff[1];
    assign dat_s    = dat_ff[1];
    assign clk_fall = clk_s_d & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clock out
// data/parity/stop on device clock falls, then check the device ACK bit.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int RTS_CYCLES     = PS2_RTS_CYCLES,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic         CLOCK_50,
    input  logic         resetn,
    ps2_host_tx_if.slave cmd,
    input  logic         ps2_clk_in,
    input  logic         ps2_dat_in,
    output logic         ps2_clk_oe,
    output logic         ps2_dat_oe
);

    localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] RTS_LAST     = 20'(RTS_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

    tx_state_t   state;
    logic [19:0] cnt;
    logic [9:0]  sh;
    logic [3:0]  bitcnt;
    logic        clk_s;
    logic        dat_s;
    logic        clk_fall;
    logic        timeout_hit;

    ps2_sync_edge u_sync (
        .clk      (CLOCK_50),
        .rst_n    (resetn),
        .clk_raw  (ps2_clk_in),
        .dat_raw  (ps2_dat_in),
        .clk_s    (clk_s),
        .dat_s    (dat_s),
        .clk_fall (clk_fall)
    );

    assign timeout_hit = (cnt == TIMEOUT_LAST);

    // One counter times inhibit, RTS and the device response; it restarts on every state change.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state         <= TX_IDLE;
            cnt           <= '0;
            sh            <= '0;
            bitcnt        <= '0;
            ps2_clk_oe    <= 1'b0;
            ps2_dat_oe    <= 1'b0;
            cmd.busy      <= 1'b0;
            cmd.cmd_done  <= 1'b0;
            cmd.cmd_error <= 1'b0;
        end else begin
            cmd.cmd_done  <= 1'b0;
            cmd.cmd_error <= 1'b0;
            cnt           <= cnt + 20'd1;
            case (state)
                TX_IDLE: begin
                    cnt <= '0;
                    if (cmd.cmd_send) begin
                        sh         <= {1'b1, odd_parity(cmd.cmd_data), cmd.cmd_data};
                        bitcnt     <= '0;
                        ps2_clk_oe <= 1'b1;
                        ps2_dat_oe <= 1'b0;
                        cmd.busy   <= 1'b1;
                        state      <= TX_INHIBIT;
                    end
                end
                TX_INHIBIT: begin
                    if (cnt == INHIBIT_LAST) begin
                        cnt        <= '0;
                        ps2_dat_oe <= 1'b1;
                        state      <= TX_RTS;
                    end
                end
                TX_RTS: begin
                    if (cnt == RTS_LAST) begin
                        cnt        <= '0;
                        ps2_clk_oe <= 1'b0;
                        state      <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (timeout_hit) begin
                        cnt           <= '0;
                        ps2_clk_oe    <= 1'b0;
                        ps2_dat_oe    <= 1'b0;
                        cmd.cmd_error <= 1'b1;
                        state         <= TX_ERROR;
                    end else if (clk_fall) begin
                        ps2_dat_oe <= ~sh[0];
                        sh         <= {1'b0, sh[9:1]};
                        bitcnt     <= bitcnt + 4'd1;
                        if (bitcnt == 4'd9) begin
                            cnt   <= '0;
                            state <= TX_ACK;
                        end
                    end
                end
                TX_ACK: begin
                    if (timeout_hit || (clk_fall && dat_s)) begin
                        cnt           <= '0;
                        ps2_clk_oe    <= 1'b0;
                        ps2_dat_oe    <= 1'b0;
                        cmd.cmd_error <= 1'b1;
                        state         <= TX_ERROR;
                    end else if (clk_fall) begin
                        cnt   <= '0;
                        state <= TX_WAIT_IDLE;
                    end
                end
                TX_WAIT_IDLE: begin
                    if (timeout_hit) begin
                        cnt           <= '0;
                        ps2_clk_oe    <= 1'b0;
                        ps2_dat_oe    <= 1'b0;
                        cmd.cmd_error <= 1'b1;
                        state         <= TX_ERROR;
                    end else if (clk_s && dat_s) begin
                        cnt          <= '0;
                        cmd.cmd_done <= 1'b1;
                        state        <= TX_DONE;
                    end
                end
                default: begin
                    // DONE and ERROR last one cycle; requests arriving here are dropped.
                    cnt        <= '0;
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    cmd.busy   <= 1'b0;
                    state      <= TX_IDLE;
                end
            endcase
        end
    end

endmodule
